// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the MIPS32 core front end.
//   - MIPS_ADDR_W / MIPS_INSTR_W : default address and instruction widths
//   - MIPS_RESET_PC              : default reset program counter (word aligned)
//   - fetch_state_t              : fetch sequencer states
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int unsigned MIPS_ADDR_W   = 32;
  localparam int unsigned MIPS_INSTR_W  = 32;
  localparam logic [31:0] MIPS_RESET_PC = 32'h0000_0000;

  // REQ   : request outstanding toward instruction memory, not yet granted
  // WAIT  : granted, waiting for the read data
  // FULL  : instruction held for decode
  // DRAIN : a granted fetch was made stale by a redirect; swallow its data
  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//   Program counter and instruction-fetch sequencer. Keeps one instruction
//   memory request in flight at most, and hands {pc, pc+4, instr} to decode
//   through a valid/ready pair. Redirects from the branch/jump target adder
//   override everything; fetches issued before a redirect are drained and
//   their data dropped.
//
// Ports
//   clk              core clock
//   rst_n            synchronous active-low reset
//   redirect_valid   taken branch/jump this cycle
//   redirect_target  new PC (low two bits ignored)
//   imem_req         fetch request (level, held until imem_gnt)
//   imem_addr        fetch address (current pc)
//   imem_gnt         memory accepted the request this cycle
//   imem_rvalid      read data valid, one per grant
//   imem_rdata       instruction word
//   if_valid         instruction held for decode
//   if_ready         decode accepts the held instruction
//   if_pc            address of the held instruction
//   if_pc_plus4      if_pc + 4, operand for the target adder
//   if_instr         held instruction word
// -----------------------------------------------------------------------------
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned        ADDR_W   = MIPS_ADDR_W,
  parameter int unsigned        INSTR_W  = MIPS_INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(MIPS_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus4,
  output logic [INSTR_W-1:0] if_instr
);

  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  fetch_state_t       state_reg,       state_next;
  logic [ADDR_W-1:0]  pc_reg,          pc_next;
  logic               if_valid_reg,    if_valid_next;
  logic [ADDR_W-1:0]  if_pc_reg,       if_pc_next;
  logic [ADDR_W-1:0]  if_pc_plus4_reg, if_pc_plus4_next;
  logic [INSTR_W-1:0] if_instr_reg,    if_instr_next;

  // ---------------------------------------------------------------------------
  // State, pc and output stage registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= REQ;
      pc_reg          <= RESET_PC;
      if_valid_reg    <= 1'b0;
      if_pc_reg       <= RESET_PC;
      if_pc_plus4_reg <= RESET_PC + PC_STEP;
      if_instr_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      if_valid_reg    <= if_valid_next;
      if_pc_reg       <= if_pc_next;
      if_pc_plus4_reg <= if_pc_plus4_next;
      if_instr_reg    <= if_instr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    if_valid_next    = if_valid_reg;
    if_pc_next       = if_pc_reg;
    if_pc_plus4_next = if_pc_plus4_reg;
    if_instr_next    = if_instr_reg;

    case (state_reg)
      REQ: begin
        // A grant in the redirect cycle means the old address is already in
        // flight at the memory, so its response has to be drained.
        if (redirect_valid) begin
          state_next = imem_gnt ? DRAIN : REQ;
        end else if (imem_gnt) begin
          state_next = WAIT;
        end
      end

      WAIT: begin
        if (redirect_valid) begin
          // Data arriving together with the redirect is for the old path.
          state_next = imem_rvalid ? REQ : DRAIN;
        end else if (imem_rvalid) begin
          if_instr_next    = imem_rdata;
          if_pc_next       = pc_reg;
          if_pc_plus4_next = pc_reg + PC_STEP;
          if_valid_next    = 1'b1;
          pc_next          = pc_reg + PC_STEP;
          state_next       = FULL;
        end
      end

      FULL: begin
        // A redirect squashes the held instruction; a simultaneous if_ready
        // still counts as a transfer on the decode side.
        if (redirect_valid || if_ready) begin
          if_valid_next = 1'b0;
          state_next    = REQ;
        end
      end

      DRAIN: begin
        if (imem_rvalid) begin
          state_next = REQ;
        end
      end

      default: begin
        state_next = REQ;
      end
    endcase

    // Redirect owns the pc in every state; the last target seen wins.
    if (redirect_valid) begin
      pc_next       = redirect_target & ALIGN_MASK;
      if_valid_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Request is gated by rst_n so it is low during the reset cycle itself.
  assign imem_req    = rst_n && (state_reg == REQ);
  assign imem_addr   = pc_reg;
  assign if_valid    = if_valid_reg;
  assign if_pc       = if_pc_reg;
  assign if_pc_plus4 = if_pc_plus4_reg;
  assign if_instr    = if_instr_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//   Randomized bench for pc_fetch_unit. A behavioural memory hands out one
//   response per grant after a random latency; a program-order model tracks
//   the address of the next instruction decode should see, and every
//   presented instruction, fetch address and reset value is compared to it.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4),
    .if_instr        (if_instr)
  );

  // Bookkeeping
  int n_checks = 0;
  int n_pass   = 0;
  int n_xfer   = 0;

  // Reference model: address of the next instruction in program order
  logic [31:0] exp_pc     = RST_PC;
  logic        last_rst   = 1'b0;  // rst_n value at the most recent edge
  logic        last_redir = 1'b0;  // redirect taken (out of reset) at that edge

  // Memory model: at most one outstanding access
  logic        mem_pend = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;

  // Stimulus knobs
  logic        rst_cmd = 1'b0;
  int          p_gnt   = 100;
  int          min_lat = 1;
  int          max_lat = 1;
  int          p_ready = 100;
  int          p_redir = 0;
  int          os_cond = 0;      // one-shot redirect trigger, 0 = none
  logic [31:0] os_tgt  = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One clock cycle: observe at the falling edge, then drive the inputs for
  // the next rising edge and advance the model to match that edge.
  task automatic step();
    logic        rv, gn, rd, rdy;
    logic [31:0] tgt;
    @(negedge clk);

    if (!last_rst) begin
      check("rst_if_valid", 32'(if_valid), 32'd0);
      check("rst_if_pc", if_pc, RST_PC);
      check("rst_if_pc_plus4", if_pc_plus4, RST_PC + 32'd4);
      check("rst_if_instr", if_instr, 32'd0);
    end else begin
      if (last_redir) check("redirect_clears_valid", 32'(if_valid), 32'd0);
      if (if_valid) begin
        check("if_pc", if_pc, exp_pc);
        check("if_pc_plus4", if_pc_plus4, exp_pc + 32'd4);
        check("if_instr", if_instr, mem_word(exp_pc));
        check("no_req_while_full", 32'(imem_req), 32'd0);
      end
    end
    if (rst_n && imem_req) check("imem_addr", imem_addr, exp_pc);

    rst_n = rst_cmd;
    #1;
    if (!rst_n) check("req_low_in_reset", 32'(imem_req), 32'd0);
    else if (!last_rst) check("req_after_reset", 32'(imem_req), 32'd1);

    rv = 1'b0;
    if (mem_pend) begin
      mem_cnt--;
      rv = (mem_cnt == 0);
    end
    gn  = imem_req && !mem_pend && ($urandom_range(99) < p_gnt);
    rdy = ($urandom_range(99) < p_ready);
    rd  = 1'b0;
    tgt = $urandom;
    if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
    case (os_cond)
      1: if (mem_pend && !rv) begin rd = 1'b1; tgt = os_tgt; os_cond = 0; end
      2: if (if_valid) begin rd = 1'b1; rdy = 1'b0; tgt = os_tgt; os_cond = 0; end
      3: if (rv) begin rd = 1'b1; tgt = os_tgt; os_cond = 0; end
      4: begin rd = 1'b1; tgt = os_tgt; os_cond = 0; end
      default: rd = ($urandom_range(99) < p_redir);
    endcase

    imem_gnt        = gn;
    imem_rvalid     = rv;
    imem_rdata      = rv ? mem_word(mem_addr) : $urandom;
    redirect_valid  = rd;
    redirect_target = tgt;
    if_ready        = rdy;

    if (!rst_n) begin
      exp_pc = RST_PC;
    end else if (rd) begin
      exp_pc = tgt & ~32'h3;
    end else if (if_valid && rdy) begin
      $display("xfer pc=%h instr=%h", if_pc, if_instr);
      exp_pc = exp_pc + 32'd4;
      n_xfer++;
    end
    if (rv) mem_pend = 1'b0;
    if (gn) begin
      mem_pend = 1'b1;
      mem_cnt  = $urandom_range(max_lat, min_lat);
      mem_addr = imem_addr;
    end
    last_rst   = rst_n;
    last_redir = rd && rst_n;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_fired(input int bound, input string tag);
    int i = 0;
    while (os_cond != 0 && i < bound) begin
      step();
      i++;
    end
    check(tag, 32'(os_cond == 0), 32'd1);
    os_cond = 0;
  endtask

  initial begin
    int x0;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;

    // Reset held for a few cycles
    rst_cmd = 1'b0;
    run(3);

    // Back-to-back fetch, latency 1, decode always ready: 3 cycles each
    rst_cmd = 1'b1; p_gnt = 100; min_lat = 1; max_lat = 1; p_ready = 100; p_redir = 0;
    x0 = n_xfer;
    run(30);
    check("throughput", 32'(n_xfer - x0), 32'd10);

    // Decode stalls: held instruction stays put, no new request
    p_ready = 0;
    run(8);
    check("hold_valid", 32'(if_valid), 32'd1);
    check("hold_no_req", 32'(imem_req), 32'd0);
    p_ready = 100;
    run(6);

    // Redirect while waiting on a slow memory
    min_lat = 3; max_lat = 3;
    os_cond = 1; os_tgt = 32'h0000_0100;
    run_until_fired(20, "redirect_in_wait_fired");
    run(20);

    // Redirect with unaligned target while holding and decode stalled
    p_ready = 0; min_lat = 1; max_lat = 1;
    os_cond = 2; os_tgt = 32'h0000_0203;
    run_until_fired(20, "redirect_in_full_fired");
    p_ready = 100;
    run(20);

    // Wrap of pc through the top of the address space
    os_cond = 4; os_tgt = 32'hFFFF_FFF8;
    run(20);

    // Redirect in the same cycle as read data
    min_lat = 2; max_lat = 2;
    os_cond = 3; os_tgt = 32'h0000_0040;
    run_until_fired(20, "redirect_with_rvalid_fired");
    run(15);

    // Reset while draining a stale fetch
    min_lat = 3; max_lat = 3;
    os_cond = 1; os_tgt = 32'h0000_0300;
    run_until_fired(20, "drain_before_reset_fired");
    rst_cmd = 1'b0;
    run(2);
    rst_cmd = 1'b1;
    run(30);

    // Fully random traffic with occasional resets
    x0 = n_xfer;
    for (int blk = 0; blk < 30; blk++) begin
      p_gnt   = $urandom_range(100, 30);
      min_lat = 1;
      max_lat = $urandom_range(4, 1);
      p_ready = $urandom_range(100, 30);
      p_redir = $urandom_range(8, 0);
      for (int i = 0; i < 100; i++) begin
        rst_cmd = ($urandom_range(299) != 0);
        step();
      end
    end
    rst_cmd = 1'b1;
    check("random_progress", 32'((n_xfer - x0) > 150), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
